// File: rtl/retire_trace_buffer_if.sv
// Retire-side and trace-side signal bundle for the retire trace buffer.
interface retire_trace_buffer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              i_retire_valid;
  logic              i_retire_halt;
  logic              i_retire_trap;
  logic [31:0]       i_retire_inst;
  logic [31:0]       i_retire_pc;
  logic [31:0]       i_retire_next_pc;
  logic [4:0]        i_retire_rd_waddr;
  logic [31:0]       i_retire_rd_wdata;

  logic              o_trace_valid;
  logic              i_trace_ready;
  logic [31:0]       o_trace_pc;
  logic [31:0]       o_trace_inst;
  logic [4:0]        o_trace_rd_waddr;
  logic [31:0]       o_trace_rd_wdata;
  logic [2:0]        o_trace_flags;

  logic [CNT_W-1:0]  o_count;
  logic              o_overflow;
  logic [15:0]       o_drop_count;
  logic              o_halted;

  modport slave (
    input  i_retire_valid, i_retire_halt, i_retire_trap, i_retire_inst,
           i_retire_pc, i_retire_next_pc, i_retire_rd_waddr, i_retire_rd_wdata,
           i_trace_ready,
    output o_trace_valid, o_trace_pc, o_trace_inst, o_trace_rd_waddr,
           o_trace_rd_wdata, o_trace_flags, o_count, o_overflow,
           o_drop_count, o_halted
  );

  modport master (
    output i_retire_valid, i_retire_halt, i_retire_trap, i_retire_inst,
           i_retire_pc, i_retire_next_pc, i_retire_rd_waddr, i_retire_rd_wdata,
           i_trace_ready,
    input  o_trace_valid, o_trace_pc, o_trace_inst, o_trace_rd_waddr,
           o_trace_rd_wdata, o_trace_flags, o_count, o_overflow,
           o_drop_count, o_halted
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Captures retired instructions into a FWFT FIFO and streams them to a trace
// sink, tracking overflow, saturating drop count and a sticky halt flag.
module retire_trace_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter bit          STOP_ON_HALT = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  retire_trace_buffer_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0]  flags;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] inst;
    logic [31:0] pc;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_q, drop_d;
  logic             halted_q, halted_d;

  logic cap, pop, push, drop, full, valid;
  rec_t new_rec, head_rec;

  // Build the record from the retire inputs; disc uses 32-bit wrap arithmetic.
  always_comb begin
    new_rec       = '0;
    new_rec.pc    = bus.i_retire_pc;
    new_rec.inst  = bus.i_retire_inst;
    new_rec.rd    = bus.i_retire_rd_waddr;
    new_rec.wdata = (bus.i_retire_rd_waddr == 5'd0) ? 32'd0 : bus.i_retire_rd_wdata;
    new_rec.flags = {(bus.i_retire_next_pc != (bus.i_retire_pc + 32'd4)),
                     bus.i_retire_halt, bus.i_retire_trap};
  end

  // Push/pop/drop decisions and next-state for pointers and status.
  always_comb begin
    valid      = (count_q != '0);
    full       = (count_q == CNT_W'(DEPTH));
    cap        = (bus.i_retire_valid | bus.i_retire_halt) & ~(STOP_ON_HALT & halted_q);
    pop        = valid & bus.i_trace_ready;
    push       = cap & (~full | pop);
    drop       = cap & full & ~pop;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    halted_d   = halted_q | (cap & bus.i_retire_halt);
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  // Record storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) mem_q[tail_q] <= new_rec;
  end

  // Head record presented directly from storage, zeroed while empty.
  always_comb begin
    head_rec = valid ? mem_q[head_q] : '0;
  end

  assign bus.o_trace_valid    = valid;
  assign bus.o_trace_pc       = head_rec.pc;
  assign bus.o_trace_inst     = head_rec.inst;
  assign bus.o_trace_rd_waddr = head_rec.rd;
  assign bus.o_trace_rd_wdata = head_rec.wdata;
  assign bus.o_trace_flags    = head_rec.flags;
  assign bus.o_count          = count_q;
  assign bus.o_overflow       = overflow_q;
  assign bus.o_drop_count     = drop_q;
  assign bus.o_halted         = halted_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed-vector bench for retire_trace_buffer (DEPTH=16, STOP_ON_HALT=1).
module tb_retire_trace_buffer;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  retire_trace_buffer_if #(.DEPTH(16)) bus ();

  retire_trace_buffer #(.DEPTH(16), .STOP_ON_HALT(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_retire(input logic v, input logic h, input logic t,
                            input logic [31:0] pc, input logic [31:0] npc,
                            input logic [31:0] inst, input logic [4:0] rd,
                            input logic [31:0] wd);
    bus.i_retire_valid    = v;
    bus.i_retire_halt     = h;
    bus.i_retire_trap     = t;
    bus.i_retire_pc       = pc;
    bus.i_retire_next_pc  = npc;
    bus.i_retire_inst     = inst;
    bus.i_retire_rd_waddr = rd;
    bus.i_retire_rd_wdata = wd;
  endtask

  task automatic idle();
    set_retire(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.i_trace_ready = 1'b0;
    idle();

    // Reset then idle
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_valid", 32'(bus.o_trace_valid), 32'd0);
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_ovf", 32'(bus.o_overflow), 32'd0);
    check("rst_drop", 32'(bus.o_drop_count), 32'd0);
    check("rst_halted", 32'(bus.o_halted), 32'd0);
    check("rst_pc", bus.o_trace_pc, 32'd0);

    // Basic flow
    bus.i_trace_ready = 1'b1;
    set_retire(1'b1, 1'b0, 1'b0, 32'h0, 32'h4, 32'h00500093, 5'd1, 32'd5);
    step();
    check("bf1_valid", 32'(bus.o_trace_valid), 32'd1);
    check("bf1_count", 32'(bus.o_count), 32'd1);
    check("bf1_pc", bus.o_trace_pc, 32'h0);
    check("bf1_inst", bus.o_trace_inst, 32'h00500093);
    check("bf1_rd", 32'(bus.o_trace_rd_waddr), 32'd1);
    check("bf1_wdata", bus.o_trace_rd_wdata, 32'd5);
    check("bf1_flags", 32'(bus.o_trace_flags), 32'd0);
    set_retire(1'b1, 1'b0, 1'b0, 32'h4, 32'h8, 32'h00208113, 5'd2, 32'd7);
    step();
    check("bf2_count", 32'(bus.o_count), 32'd1);
    check("bf2_pc", bus.o_trace_pc, 32'h4);
    check("bf2_flags", 32'(bus.o_trace_flags), 32'd0);
    idle();
    step();
    check("bf_empty", 32'(bus.o_trace_valid), 32'd0);

    // Branch/trap flags, rd=0 data masking, PC wrap
    set_retire(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 32'h00000063, 5'd0, 32'd0);
    step();
    check("trap_flags", 32'(bus.o_trace_flags), 32'b101);
    check("trap_pc", bus.o_trace_pc, 32'h10);
    set_retire(1'b1, 1'b0, 1'b0, 32'h44, 32'h48, 32'h00000013, 5'd0, 32'hDEADBEEF);
    step();
    check("rd0_wdata", bus.o_trace_rd_wdata, 32'd0);
    check("rd0_flags", 32'(bus.o_trace_flags), 32'd0);
    set_retire(1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h00000013, 5'd3, 32'd7);
    step();
    check("wrap_pc", bus.o_trace_pc, 32'hFFFFFFFC);
    check("wrap_flags", 32'(bus.o_trace_flags), 32'd0);
    check("wrap_wdata", bus.o_trace_rd_wdata, 32'd7);
    idle();
    step();
    check("flags_empty", 32'(bus.o_count), 32'd0);

    // Overflow: 20 retires with sink stalled
    bus.i_trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_retire(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4*i), 32'h104 + 32'(4*i),
                 32'h1000 + 32'(i), 5'd1, 32'(i));
      step();
    end
    idle();
    check("ovf_count", 32'(bus.o_count), 32'd16);
    check("ovf_flag", 32'(bus.o_overflow), 32'd1);
    check("ovf_drop", 32'(bus.o_drop_count), 32'd4);
    check("ovf_head", bus.o_trace_pc, 32'h100);
    step();
    check("ovf_hold", bus.o_trace_inst, 32'h1000);
    bus.i_trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain", bus.o_trace_pc, 32'h100 + 32'(4*i));
      step();
    end
    check("ovf_drained", 32'(bus.o_trace_valid), 32'd0);

    // Full with simultaneous push and pop
    bus.i_trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_retire(1'b1, 1'b0, 1'b0, 32'h200 + 32'(4*i), 32'h204 + 32'(4*i),
                 32'h13, 5'd1, 32'd1);
      step();
    end
    check("fp_full", 32'(bus.o_count), 32'd16);
    set_retire(1'b1, 1'b0, 1'b0, 32'h300, 32'h304, 32'h13, 5'd1, 32'd1);
    bus.i_trace_ready = 1'b1;
    step();
    idle();
    check("fp_count", 32'(bus.o_count), 32'd16);
    check("fp_drop", 32'(bus.o_drop_count), 32'd4);
    check("fp_head", bus.o_trace_pc, 32'h204);
    for (int i = 0; i < 16; i++) begin
      check("fp_drain", bus.o_trace_pc, (i < 15) ? 32'h204 + 32'(4*i) : 32'h300);
      step();
    end
    check("fp_empty", 32'(bus.o_count), 32'd0);

    // Halt with STOP_ON_HALT
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("h_rst_ovf", 32'(bus.o_overflow), 32'd0);
    check("h_rst_drop", 32'(bus.o_drop_count), 32'd0);
    bus.i_trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_retire(1'b1, 1'b0, 1'b0, 32'h400 + 32'(4*i), 32'h404 + 32'(4*i),
                 32'h13, 5'd1, 32'd1);
      step();
    end
    set_retire(1'b0, 1'b1, 1'b0, 32'h40C, 32'h410, 32'h00100073, 5'd0, 32'd0);
    step();
    check("h_halted", 32'(bus.o_halted), 32'd1);
    check("h_count4", 32'(bus.o_count), 32'd4);
    for (int i = 0; i < 2; i++) begin
      set_retire(1'b1, 1'b0, 1'b0, 32'h410 + 32'(4*i), 32'h414 + 32'(4*i),
                 32'h13, 5'd1, 32'd1);
      step();
    end
    idle();
    check("h_ignored", 32'(bus.o_count), 32'd4);
    check("h_drop", 32'(bus.o_drop_count), 32'd0);
    check("h_ovf", 32'(bus.o_overflow), 32'd0);
    bus.i_trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("h_drain", bus.o_trace_pc, 32'h400 + 32'(4*i));
      if (i == 3) begin
        check("h_last_flags", 32'(bus.o_trace_flags), 32'b010);
        check("h_last_inst", bus.o_trace_inst, 32'h00100073);
      end
      step();
    end
    check("h_empty", 32'(bus.o_trace_valid), 32'd0);

    // Reset mid-drain
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("md_unhalt", 32'(bus.o_halted), 32'd0);
    bus.i_trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_retire(1'b1, 1'b0, 1'b0, 32'h500 + 32'(4*i), 32'h504 + 32'(4*i),
                 32'h13, 5'd1, 32'd1);
      step();
    end
    idle();
    bus.i_trace_ready = 1'b1;
    step();
    check("md_count", 32'(bus.o_count), 32'd2);
    check("md_head", bus.o_trace_pc, 32'h504);
    rst_n = 1'b0;
    set_retire(1'b1, 1'b0, 1'b0, 32'h600, 32'h604, 32'h13, 5'd1, 32'd1);
    step();
    check("md_rst_count", 32'(bus.o_count), 32'd0);
    check("md_rst_valid", 32'(bus.o_trace_valid), 32'd0);
    check("md_rst_pc", bus.o_trace_pc, 32'd0);
    rst_n = 1'b1;
    idle();
    step();
    check("md_idle", 32'(bus.o_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
Consumer at the far end of the hart's retire interface. It captures each retired instruction into a first-word-fall-through FIFO and streams the records out over a valid/ready port to a trace sink such as a bench scoreboard or debug UART. It tracks overflow, drop count and a sticky halt indication, so no trace loss goes unnoticed.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
STOP_ON_HALT, 1, when 1 the buffer ignores all retire activity after a halt record is captured.

Ports:
i_clk  in  1  global clock
i_rst_n  in  1  synchronous active-low reset
i_retire_valid  in  1  instruction retiring this cycle
i_retire_halt  in  1  ebreak retiring; may be high while i_retire_valid is low
i_retire_trap  in  1  retiring instruction trapped
i_retire_inst  in  32  retired instruction word
i_retire_pc  in  32  PC of retired instruction
i_retire_next_pc  in  32  next PC
i_retire_rd_waddr  in  5  destination register (0 = none)
i_retire_rd_wdata  in  32  destination write data
o_trace_valid  out  1  head record available
i_trace_ready  in  1  sink accepts head record
o_trace_pc  out  32  head record PC
o_trace_inst  out  32  head record instruction
o_trace_rd_waddr  out  5  head record rd
o_trace_rd_wdata  out  32  head record rd data; forced to 0 when rd is 0
o_trace_flags  out  3  {disc, halt, trap}; disc = next_pc != pc + 4 (mod 2^32)
o_count  out  clog2(DEPTH)+1  occupancy
o_overflow  out  1  sticky; at least one record dropped
o_drop_count  out  16  dropped records, saturating at 16'hFFFF
o_halted  out  1  sticky; halt record captured

Behaviour:
- Reset (i_rst_n low at a rising edge) clears the pointers, o_count, o_overflow, o_drop_count and o_halted. o_trace_valid becomes 0 and all o_trace_* data outputs read 0. Reset overrides push and pop in the same cycle. Reset mid-stream discards all buffered records.
- Capture condition: cap = (i_retire_valid | i_retire_halt) & ~(STOP_ON_HALT & o_halted).
- Pop condition: pop = o_trace_valid & i_trace_ready.
- Push: when cap is high and (o_count < DEPTH or pop), write a record to the tail and advance the tail pointer (wraps mod DEPTH).
- Full: when cap is high, o_count == DEPTH and pop is low, the record is dropped. o_overflow is set and o_drop_count increments, saturating.
- Simultaneous push and pop when full: both occur and the count stays at DEPTH. No drop.
- Simultaneous push and pop when empty: no pop (o_trace_valid is low), so the push lands and count becomes 1.
- Occupancy: o_count updates by +1, -1 or 0 on each edge; it never exceeds DEPTH and never goes below 0.
- Latency: a record captured at edge N is presented with o_trace_valid high after edge N (first-word-fall-through, one cycle). o_trace_* is driven from storage at the head pointer; with o_trace_valid = (o_count != 0), the outputs are combinational from registered state.
- Output stability: while o_trace_valid is high and i_trace_ready is low, all o_trace_* values hold stable.
- Halt: o_halted sets on the edge where a record with i_retire_halt high is pushed. A dropped halt record also sets o_halted.
  - STOP_ON_HALT = 1: after halt, cap is low; ignored retires are not counted as drops. Buffered records continue to drain normally.
  - STOP_ON_HALT = 0: o_halted is informational only.
- Flags: disc is computed at capture from the inputs using 32-bit wrap arithmetic. PC 32'hFFFFFFFC with next_pc 0 gives disc = 0.
- Pointers are clog2(DEPTH) bits and wrap naturally. The full/empty distinction comes from o_count.

Test Plan:
- Reset then idle: hold i_rst_n low 2 cycles, then release -> o_trace_valid=0, o_count=0, o_overflow=0, o_drop_count=0, o_halted=0.
- Basic flow: retire pc=0x0 inst=0x00500093 rd=1 wdata=5, then pc=0x4 next_pc=0x8, with ready=1 -> valid high one cycle after each push; records emerge in order with flags=3'b000; count peaks at 1.
- Branch/trap flags: retire pc=0x10 next_pc=0x40 with trap=1 -> flags=3'b101. Retire with rd=0, wdata=0xDEADBEEF -> o_trace_rd_wdata=0.
- Overflow (DEPTH=16): ready=0, 20 consecutive retires -> count=16, o_overflow=1, o_drop_count=4; the head record is still the first retire. Then ready=1 -> exactly 16 records drain in order.
- Full with simultaneous pop: fill to 16, then one cycle with retire and ready both high -> count stays 16, o_drop_count unchanged, the new record becomes the last entry.
- Halt: retire 3 instructions, then valid=0 halt=1 with inst=0x00100073, then 2 more retires -> o_halted=1, exactly 4 records drain, the last with flags halt bit=1, o_drop_count=0. Asserting reset mid-drain clears everything within one edge.
